alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares the single execute-stage ALU between two requesters (0 = main pipe, 1 = aux/address unit).
//  Round-robin grant, 2-stage pipeline (operand latch -> ALU eval/result reg).
//  Owns the architectural NZCV status register, evaluates ARM condition codes, supplies ALU carryIn.
//  Sits between the issue logic and the combinational ALU; the ALU itself is unchanged.
// PARAMETERS
//  DW  32  operand/result width (ALU is fixed at 32; other values unsupported)
// PORTS
//  clk          in   1   clock, rising edge
//  rst_n        in   1   asynchronous, active-low reset
//  req0/req1    in   1   request valid; held with stable payload until gntX
//  cmd0/cmd1    in   4   ALU exeCommand
//  a0/a1,b0/b1  in   DW  operands A, B
//  s0/s1        in   1   1 = update NZCV if executed
//  cond0/cond1  in   4   ARM condition field
//  gnt0/gnt1    out  1   combinational one-cycle grant; payload accepted this edge
//  flush        in   1   kill stage-1 op (no response, no flag update)
//  alu_a,alu_b  out  DW  to ALU inputA/inputB (from stage-1 regs)
//  alu_cmd      out  4   to ALU exeCommand
//  alu_cin      out  1   to ALU carryIn = status_q[C]
//  alu_result   in   DW  from ALU result
//  alu_status   in   4   from ALU statusOut {N,Z,C,V}
//  rsp_valid    out  1   response pulse
//  rsp_id       out  1   requester of response
//  rsp_exec     out  1   1 = condition passed, op executed
//  rsp_result   out  DW  result; 0 when rsp_exec=0
//  status_q     out  4   architectural {N,Z,C,V}
// BEHAVIOUR
//  Reset (async, rst_n=0): s1_valid=0, rsp_valid=0, rsp_id=0, rsp_exec=0, rsp_result=0,
//   status_q=4'b0000, last=1 (so requester 0 wins first tie). gnt0/gnt1=0 while in reset.
//  Arbitration: one req -> grant it; both -> grant ~last; neither -> none. last<=granted id.
//   At most one gnt per cycle. No backpressure: a grant is issued every cycle there is a request.
//  Stage 1 (edge after grant): latch id, cmd, a, b, s, cond; s1_valid<=1. alu_* driven from regs.
//  Cond eval (stage 1, against status_q): EQ Z | NE ~Z | CS C | CC ~C | MI N | PL ~N | VS V |
//   VC ~V | HI C&~Z | LS ~C|Z | GE N==V | LT N!=V | GT ~Z&(N==V) | LE Z|(N!=V) | AL 1 | 1111 0.
//  Stage 2 (next edge): rsp_valid<=s1_valid&~flush; rsp_id, rsp_exec<=pass;
//   rsp_result<=pass ? alu_result : 0; if s1_valid&~flush&pass&s: status_q<=alu_status.
//  Latency: gnt at cycle t -> rsp_valid at t+2. Throughput 1 op/cycle.
//  Back-to-back: flags written by op N at edge t+2 are seen by op N+1's cond eval
//   in cycle t+2; no hazard, no stall.
//  flush: kills only the stage-1 op; a same-cycle grant is still accepted into stage 1.
//  Simultaneous flush & no stage-1 op: no effect.
//  Reset mid-operation: in-flight ops dropped, no response, flags cleared.
//  Requester dropping req before gnt: legal; no grant, no state change.
// STRUCTURE
//  alu_defs.vh: EXE_* command codes, COND_* codes, status bit indices
//   N=3, Z=2, C=1, V=0; shared with decoder and ALU.
//  Sub-module cond_check (combinational: cond[3:0], nzcv[3:0] -> pass).
//  Arbiter, stage regs and status reg stay inline.
// TESTING
//  1 Reset then req0 ADD a=5 b=7 cond=AL s=1 -> gnt0 t, rsp t+2 id0 exec1 result=12, NZCV=0000.
//  2 req0&req1 held 4 cycles -> gnt 0,1,0,1. Responses alternate id with 2-cycle lag.
//  3 SUB a=3 b=3 s=1 then next-cycle MOV b=9 cond=EQ -> 2nd exec1 result=9. Same with cond=NE -> exec0 result=0, flags Z=1 unchanged.
//  4 ADD a=8000_0000 b=8000_0000 s=1 -> result 0, NZCV=0111; next ADC a=1 b=1 -> alu_cin=1, result=3.
//  5 flush with op in stage 1 (s=1) -> no rsp_valid, status_q unchanged; concurrently granted op responds normally.
//  6 rst_n low for 1 cycle with 2 ops in flight -> no responses, status_q=0000, next tie grants req0.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the execute-stage ALU arbiter: command/condition codes,
// NZCV bit positions, the stage-1 control record and the round-robin pick.
package alu_arbiter_pkg;

  localparam int ALU_DW = 32;

  localparam int ST_N = 3;
  localparam int ST_Z = 2;
  localparam int ST_C = 1;
  localparam int ST_V = 0;

  typedef enum logic [3:0] {
    EXE_AND = 4'h0,
    EXE_EOR = 4'h1,
    EXE_SUB = 4'h2,
    EXE_RSB = 4'h3,
    EXE_ADD = 4'h4,
    EXE_ADC = 4'h5,
    EXE_SBC = 4'h6,
    EXE_RSC = 4'h7,
    EXE_TST = 4'h8,
    EXE_TEQ = 4'h9,
    EXE_CMP = 4'hA,
    EXE_CMN = 4'hB,
    EXE_ORR = 4'hC,
    EXE_MOV = 4'hD,
    EXE_BIC = 4'hE,
    EXE_MVN = 4'hF
  } exe_cmd_e;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_e;

  typedef struct packed {
    logic     id;
    exe_cmd_e cmd;
    logic     s;
    cond_e    cond;
  } op_ctl_t;

  // Returns {gnt1, gnt0}; on a tie the requester not granted last wins.
  function automatic logic [1:0] rr_pick(input logic req0, input logic req1, input logic last);
    logic [1:0] g;
    g = 2'b00;
    if (req0 && req1) begin
      g = last ? 2'b01 : 2'b10;
    end else if (req0) begin
      g = 2'b01;
    end else if (req1) begin
      g = 2'b10;
    end
    return g;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester, ALU and response signals of the ALU arbiter; slave = arbiter side,
// master = issue logic / ALU / consumer side.
interface alu_arbiter_if #(
  parameter int DW = 32
);
  logic          req0;
  logic          req1;
  logic [3:0]    cmd0;
  logic [3:0]    cmd1;
  logic [DW-1:0] a0;
  logic [DW-1:0] a1;
  logic [DW-1:0] b0;
  logic [DW-1:0] b1;
  logic          s0;
  logic          s1;
  logic [3:0]    cond0;
  logic [3:0]    cond1;
  logic          gnt0;
  logic          gnt1;
  logic          flush;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [3:0]    alu_cmd;
  logic          alu_cin;
  logic [DW-1:0] alu_result;
  logic [3:0]    alu_status;
  logic          rsp_valid;
  logic          rsp_id;
  logic          rsp_exec;
  logic [DW-1:0] rsp_result;
  logic [3:0]    status_q;

  modport slave (
    input  req0, req1, cmd0, cmd1, a0, a1, b0, b1, s0, s1, cond0, cond1, flush,
    input  alu_result, alu_status,
    output gnt0, gnt1, alu_a, alu_b, alu_cmd, alu_cin,
    output rsp_valid, rsp_id, rsp_exec, rsp_result, status_q
  );

  modport master (
    output req0, req1, cmd0, cmd1, a0, a1, b0, b1, s0, s1, cond0, cond1, flush,
    output alu_result, alu_status,
    input  gnt0, gnt1, alu_a, alu_b, alu_cmd, alu_cin,
    input  rsp_valid, rsp_id, rsp_exec, rsp_result, status_q
  );

endinterface

// File: rtl/alu_arbiter_cond_check.sv
// ARM condition-code evaluation against an {N,Z,C,V} word; purely combinational.
module alu_arbiter_cond_check
  import alu_arbiter_pkg::*;
(
  input  cond_e      cond_i,
  input  logic [3:0] nzcv_i,
  output logic       pass_o
);

  logic n, z, c, v;

  assign n = nzcv_i[ST_N];
  assign z = nzcv_i[ST_Z];
  assign c = nzcv_i[ST_C];
  assign v = nzcv_i[ST_V];

  always_comb begin
    pass_o = 1'b0;
    case (cond_i)
      COND_EQ: pass_o = z;
      COND_NE: pass_o = ~z;
      COND_CS: pass_o = c;
      COND_CC: pass_o = ~c;
      COND_MI: pass_o = n;
      COND_PL: pass_o = ~n;
      COND_VS: pass_o = v;
      COND_VC: pass_o = ~v;
      COND_HI: pass_o = c & ~z;
      COND_LS: pass_o = ~c | z;
      COND_GE: pass_o = (n == v);
      COND_LT: pass_o = (n != v);
      COND_GT: pass_o = ~z & (n == v);
      COND_LE: pass_o = z | (n != v);
      COND_AL: pass_o = 1'b1;
      default: pass_o = 1'b0;  // NV never executes
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares the execute-stage ALU between main pipe (0) and aux unit (1): round-robin grant,
// operand latch then result register (gnt -> rsp two cycles later), owns NZCV and cond eval.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int DW = ALU_DW
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus
);

  logic [1:0]    gnt;
  logic          last_q, last_d;
  logic          s1_valid_q, s1_valid_d;
  op_ctl_t       s1_ctl_q, s1_ctl_d;
  logic [DW-1:0] s1_a_q, s1_a_d;
  logic [DW-1:0] s1_b_q, s1_b_d;
  logic          pass;
  logic          fire;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_id_q, rsp_id_d;
  logic          rsp_exec_q, rsp_exec_d;
  logic [DW-1:0] rsp_result_q, rsp_result_d;
  logic [3:0]    status_q, status_d;

  // Grant and stage-1 capture; flush never blocks a same-cycle grant.
  always_comb begin
    gnt        = rr_pick(bus.req0, bus.req1, last_q) & {2{rst_n}};
    last_d     = last_q;
    s1_valid_d = |gnt;
    s1_ctl_d   = s1_ctl_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    if (gnt[0]) begin
      last_d   = 1'b0;
      s1_ctl_d = '{id: 1'b0, cmd: exe_cmd_e'(bus.cmd0), s: bus.s0, cond: cond_e'(bus.cond0)};
      s1_a_d   = bus.a0;
      s1_b_d   = bus.b0;
    end else if (gnt[1]) begin
      last_d   = 1'b1;
      s1_ctl_d = '{id: 1'b1, cmd: exe_cmd_e'(bus.cmd1), s: bus.s1, cond: cond_e'(bus.cond1)};
      s1_a_d   = bus.a1;
      s1_b_d   = bus.b1;
    end
  end

  alu_arbiter_cond_check u_cond_check (
    .cond_i (s1_ctl_q.cond),
    .nzcv_i (status_q),
    .pass_o (pass)
  );

  assign fire = s1_valid_q & ~bus.flush;

  // Flags written here are visible to the very next stage-1 op, so no hazard logic is needed.
  always_comb begin
    rsp_valid_d  = fire;
    rsp_id_d     = rsp_id_q;
    rsp_exec_d   = rsp_exec_q;
    rsp_result_d = rsp_result_q;
    status_d     = status_q;
    if (fire) begin
      rsp_id_d     = s1_ctl_q.id;
      rsp_exec_d   = pass;
      rsp_result_d = pass ? bus.alu_result : '0;
      if (pass && s1_ctl_q.s) begin
        status_d = bus.alu_status;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q       <= 1'b1;
      s1_valid_q   <= 1'b0;
      s1_ctl_q     <= '0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_exec_q   <= 1'b0;
      rsp_result_q <= '0;
      status_q     <= 4'b0000;
    end else begin
      last_q       <= last_d;
      s1_valid_q   <= s1_valid_d;
      s1_ctl_q     <= s1_ctl_d;
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_exec_q   <= rsp_exec_d;
      rsp_result_q <= rsp_result_d;
      status_q     <= status_d;
    end
  end

  assign bus.gnt0       = gnt[0];
  assign bus.gnt1       = gnt[1];
  assign bus.alu_a      = s1_a_q;
  assign bus.alu_b      = s1_b_q;
  assign bus.alu_cmd    = s1_ctl_q.cmd;
  assign bus.alu_cin    = status_q[ST_C];
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_exec   = rsp_exec_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.status_q   = status_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU, response scoreboard, vector table and corner sequences.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_arbiter_if #(.DW(32)) bus();

  alu_arbiter #(.DW(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [35:0] alu_model(input logic [3:0] cmd, input logic [31:0] a,
                                            input logic [31:0] b, input logic cin);
    logic [31:0] x, y, r;
    logic [32:0] sum;
    logic        ci, arith, v;
    x = a; y = b; ci = 1'b0; arith = 1'b1; r = '0;
    case (cmd)
      4'h2, 4'hA: begin y = ~b; ci = 1'b1; end
      4'h3:       begin x = b; y = ~a; ci = 1'b1; end
      4'h4, 4'hB: ci = 1'b0;
      4'h5:       ci = cin;
      4'h6:       begin y = ~b; ci = cin; end
      4'h7:       begin x = b; y = ~a; ci = cin; end
      default:    arith = 1'b0;
    endcase
    sum = {1'b0, x} + {1'b0, y} + {32'd0, ci};
    case (cmd)
      4'h0, 4'h8: r = a & b;
      4'h1, 4'h9: r = a ^ b;
      4'hC:       r = a | b;
      4'hD:       r = b;
      4'hE:       r = a & ~b;
      4'hF:       r = ~b;
      default:    r = sum[31:0];
    endcase
    v = arith & (x[31] == y[31]) & (r[31] != x[31]);
    return {r[31], r == 32'd0, arith ? sum[32] : cin, v, r};
  endfunction

  assign {bus.alu_status, bus.alu_result} = alu_model(bus.alu_cmd, bus.alu_a, bus.alu_b, bus.alu_cin);

  typedef struct {
    logic [3:0]  cmd;
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [3:0]  cond;
    logic        cin;
    logic        exec;
    logic [31:0] res;
    logic [3:0]  nzcv;
  } vec_t;

  typedef struct {
    logic        id;
    logic        exec;
    logic [31:0] res;
    int          cyc;
  } exp_t;

  vec_t        vt[20];
  exp_t        sbq[$];
  exp_t        mon_e;
  int          nvec = 0;
  int          nerr = 0;
  int          cyc = 0;
  logic        prev_gnt = 1'b0;
  logic        e0_exec = 1'b0, e1_exec = 1'b0;
  logic [31:0] e0_res = '0, e1_res = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [3:0] cond, input logic ex, input logic [31:0] res);
    bus.req0 = 1'b1; bus.cmd0 = cmd; bus.a0 = a; bus.b0 = b; bus.s0 = s; bus.cond0 = cond;
    e0_exec = ex; e0_res = res;
  endtask

  task automatic drive1(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [3:0] cond, input logic ex, input logic [31:0] res);
    bus.req1 = 1'b1; bus.cmd1 = cmd; bus.a1 = a; bus.b1 = b; bus.s1 = s; bus.cond1 = cond;
    e1_exec = ex; e1_res = res;
  endtask

  // Scoreboard: push on grant, drop the stage-1 op on flush, pop and compare on response.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      chk("rsp_valid_in_reset", bus.rsp_valid, 1'b0);
      sbq.delete();
      prev_gnt = 1'b0;
    end else begin
      if (bus.rsp_valid) begin
        if (sbq.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL unexpected_rsp: got id %0d result %0h, expected no response (t=%0t)",
                   bus.rsp_id, bus.rsp_result, $time);
        end else begin
          mon_e = sbq.pop_front();
          chk("rsp_id", bus.rsp_id, mon_e.id);
          chk("rsp_exec", bus.rsp_exec, mon_e.exec);
          chk("rsp_result", bus.rsp_result, mon_e.res);
          chk("rsp_latency", cyc, mon_e.cyc + 2);
        end
      end
      if (bus.flush && prev_gnt && sbq.size() > 0) begin
        void'(sbq.pop_back());
      end
      if (bus.gnt0) sbq.push_back('{1'b0, e0_exec, e0_res, cyc});
      if (bus.gnt1) sbq.push_back('{1'b1, e1_exec, e1_res, cyc});
      prev_gnt = bus.gnt0 | bus.gnt1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.flush = 1'b0;
    bus.cmd0 = '0; bus.a0 = '0; bus.b0 = '0; bus.s0 = 1'b0; bus.cond0 = '0;
    bus.cmd1 = '0; bus.a1 = '0; bus.b1 = '0; bus.s1 = 1'b0; bus.cond1 = '0;

    //          cmd      a             b             s     cond     cin   exec  res            nzcv
    vt[0]  = '{EXE_ADD, 32'd5,        32'd7,        1'b1, COND_AL, 1'b0, 1'b1, 32'd12,        4'b0000};
    vt[1]  = '{EXE_SUB, 32'd3,        32'd3,        1'b1, COND_AL, 1'b0, 1'b1, 32'd0,         4'b0110};
    vt[2]  = '{EXE_MOV, 32'd0,        32'd9,        1'b0, COND_EQ, 1'b1, 1'b1, 32'd9,         4'b0110};
    vt[3]  = '{EXE_MOV, 32'd0,        32'd9,        1'b1, COND_NE, 1'b1, 1'b0, 32'd0,         4'b0110};
    vt[4]  = '{EXE_ADD, 32'h8000_0000, 32'h8000_0000, 1'b1, COND_AL, 1'b1, 1'b1, 32'd0,       4'b0111};
    vt[5]  = '{EXE_ADC, 32'd1,        32'd1,        1'b0, COND_AL, 1'b1, 1'b1, 32'd3,         4'b0111};
    vt[6]  = '{EXE_MOV, 32'd0,        32'd5,        1'b0, COND_VS, 1'b1, 1'b1, 32'd5,         4'b0111};
    vt[7]  = '{EXE_MOV, 32'd0,        32'd5,        1'b0, COND_GE, 1'b1, 1'b0, 32'd0,         4'b0111};
    vt[8]  = '{EXE_MOV, 32'd0,        32'd6,        1'b0, COND_LT, 1'b1, 1'b1, 32'd6,         4'b0111};
    vt[9]  = '{EXE_MOV, 32'd0,        32'd6,        1'b1, COND_HI, 1'b1, 1'b0, 32'd0,         4'b0111};
    vt[10] = '{EXE_MOV, 32'd0,        32'd7,        1'b0, COND_LS, 1'b1, 1'b1, 32'd7,         4'b0111};
    vt[11] = '{EXE_SUB, 32'd1,        32'd2,        1'b1, COND_AL, 1'b1, 1'b1, 32'hFFFF_FFFF, 4'b1000};
    vt[12] = '{EXE_MOV, 32'd0,        32'd1,        1'b0, COND_MI, 1'b0, 1'b1, 32'd1,         4'b1000};
    vt[13] = '{EXE_MOV, 32'd0,        32'd1,        1'b0, COND_PL, 1'b0, 1'b0, 32'd0,         4'b1000};
    vt[14] = '{EXE_MOV, 32'd0,        32'd2,        1'b0, COND_GT, 1'b0, 1'b0, 32'd0,         4'b1000};
    vt[15] = '{EXE_MOV, 32'd0,        32'd2,        1'b0, COND_LE, 1'b0, 1'b1, 32'd2,         4'b1000};
    vt[16] = '{EXE_MOV, 32'd0,        32'd3,        1'b0, COND_CC, 1'b0, 1'b1, 32'd3,         4'b1000};
    vt[17] = '{EXE_MOV, 32'd0,        32'd3,        1'b1, COND_NV, 1'b0, 1'b0, 32'd0,         4'b1000};
    vt[18] = '{EXE_AND, 32'hFF00,     32'h0F0F,     1'b1, COND_AL, 1'b0, 1'b1, 32'h0F00,      4'b0000};
    vt[19] = '{EXE_ADD, 32'h8000_0000, 32'h8000_0000, 1'b0, COND_AL, 1'b0, 1'b1, 32'd0,       4'b0000};

    // Reset values, with a request held to show grants are suppressed.
    bus.req0 = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_gnt0", bus.gnt0, 1'b0);
    chk("reset_rsp_id", bus.rsp_id, 1'b0);
    chk("reset_rsp_exec", bus.rsp_exec, 1'b0);
    chk("reset_rsp_result", bus.rsp_result, 32'd0);
    chk("reset_status", bus.status_q, 4'b0000);
    bus.req0 = 1'b0;
    tick();
    rst_n = 1'b1;

    // Single-requester vector table, one op at a time.
    for (int i = 0; i < 20; i++) begin
      tick();
      drive0(vt[i].cmd, vt[i].a, vt[i].b, vt[i].s, vt[i].cond, vt[i].exec, vt[i].res);
      @(negedge clk);
      chk($sformatf("v%0d_gnt0", i), bus.gnt0, 1'b1);
      tick();
      bus.req0 = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_alu_cin", i), bus.alu_cin, vt[i].cin);
      tick();
      @(negedge clk);
      chk($sformatf("v%0d_status", i), bus.status_q, vt[i].nzcv);
    end

    // Back-to-back: MOV EQ must see the Z written by the SUB just ahead of it.
    tick();
    drive0(EXE_SUB, 32'd3, 32'd3, 1'b1, COND_AL, 1'b1, 32'd0);
    @(negedge clk);
    chk("b2b_gnt_sub", bus.gnt0, 1'b1);
    tick();
    drive0(EXE_MOV, 32'd0, 32'd9, 1'b0, COND_EQ, 1'b1, 32'd9);
    @(negedge clk);
    chk("b2b_gnt_mov", bus.gnt0, 1'b1);
    tick();
    bus.req0 = 1'b0;
    tick();
    @(negedge clk);
    chk("b2b_status", bus.status_q, 4'b0110);

    // Flush the stage-1 SUB while a req1 op is granted in the same cycle.
    tick();
    drive0(EXE_SUB, 32'd1, 32'd2, 1'b1, COND_AL, 1'b1, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("flush_gnt0", bus.gnt0, 1'b1);
    tick();
    bus.req0 = 1'b0;
    drive1(EXE_MOV, 32'd0, 32'h55, 1'b0, COND_AL, 1'b1, 32'h55);
    bus.flush = 1'b1;
    @(negedge clk);
    chk("flush_gnt1", bus.gnt1, 1'b1);
    tick();
    bus.req1 = 1'b0;
    bus.flush = 1'b0;
    @(negedge clk);
    chk("flush_no_rsp", bus.rsp_valid, 1'b0);
    tick();
    @(negedge clk);
    chk("flush_status", bus.status_q, 4'b0110);
    tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    @(negedge clk);
    chk("idle_flush_no_rsp", bus.rsp_valid, 1'b0);
    chk("idle_flush_status", bus.status_q, 4'b0110);

    // Reset with two ops in flight, then a held tie must alternate starting at req0.
    tick();
    drive0(EXE_ADD, 32'h8000_0000, 32'h8000_0000, 1'b1, COND_AL, 1'b1, 32'd0);
    @(negedge clk);
    chk("inflight_gnt0", bus.gnt0, 1'b1);
    tick();
    bus.req0 = 1'b0;
    drive1(EXE_MOV, 32'd0, 32'h77, 1'b0, COND_AL, 1'b1, 32'h77);
    @(negedge clk);
    chk("inflight_gnt1", bus.gnt1, 1'b1);
    tick();
    rst_n = 1'b0;
    drive0(EXE_MOV, 32'd0, 32'h10, 1'b0, COND_AL, 1'b1, 32'h10);
    drive1(EXE_MOV, 32'd0, 32'h21, 1'b0, COND_AL, 1'b1, 32'h21);
    @(negedge clk);
    chk("midrst_gnt0", bus.gnt0, 1'b0);
    chk("midrst_gnt1", bus.gnt1, 1'b0);
    chk("midrst_status", bus.status_q, 4'b0000);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("tie%0d_gnt0", k), bus.gnt0, (k % 2) == 0);
      chk($sformatf("tie%0d_gnt1", k), bus.gnt1, (k % 2) == 1);
      tick();
      if ((k % 2) == 0) drive0(EXE_MOV, 32'd0, 32'h10 + k + 2, 1'b0, COND_AL, 1'b1, 32'h10 + k + 2);
      else              drive1(EXE_MOV, 32'd0, 32'h20 + k + 2, 1'b0, COND_AL, 1'b1, 32'h20 + k + 2);
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    chk("pending_rsp_count", sbq.size(), 32'd0);
    chk("final_status", bus.status_q, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
